fifo_1024x32b: RTL and testbench



---
 rtl/fifo_1024x32b.sv | 103 ++++++++++
 tb/tb_fifo_1024x32b.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_1024x32b.sv
// fifo_1024x32b: single-clock 1024 x 32-bit FIFO with registered data output,
// registered full/empty/almost flags and a fill-level output.
// rd_clk is accepted for port compatibility only; every register uses wr_clk.
// Optional macro FIFO_WR_WATER_LEVEL_EN adds wr_water_level, a copy of rd_water_level.
module fifo_1024x32b #(
   parameter int ALMOST_FULL_NUM  = 1020,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic        wr_clk,
   input  logic        rd_clk,
   input  logic        wr_rst,
   input  logic        rd_rst,
   input  logic [31:0] wr_data,
   input  logic        wr_en,
   output logic        wr_full,
   output logic        almost_full,
   input  logic        rd_en,
   output logic [31:0] rd_data,
   output logic        rd_empty,
   output logic [10:0] rd_water_level,
`ifdef FIFO_WR_WATER_LEVEL_EN
   output logic [10:0] wr_water_level,
`endif
   output logic        almost_empty
);

   localparam logic [10:0] DEPTH    = 11'd1024;
   localparam logic [10:0] AF_LEVEL = 11'(ALMOST_FULL_NUM);
   localparam logic [10:0] AE_LEVEL = 11'(ALMOST_EMPTY_NUM);

   logic [31:0] mem [0:1023];
   logic [9:0]  wr_ptr;
   logic [9:0]  rd_ptr;
   logic [10:0] count;
   logic [10:0] count_next;
   logic        rst;
   logic        wr_acc;
   logic        rd_acc;
   logic        unused_rd_clk;

   // rd_clk must be the same net as wr_clk, so it is intentionally left unused
   assign unused_rd_clk = rd_clk;

   assign rst    = wr_rst | rd_rst;
   // Acceptance uses the registered flags, so a full FIFO still takes a read
   // and an empty FIFO still takes a write in the same cycle.
   assign wr_acc = wr_en & ~wr_full;
   assign rd_acc = rd_en & ~rd_empty;

   assign rd_water_level = count;
`ifdef FIFO_WR_WATER_LEVEL_EN
   assign wr_water_level = count;
`endif

   // Next fill level from the accepted write/read pair
   always_comb begin
      // NOTE: default assigned first so every path drives count_next and no latch is inferred.
      count_next = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + 11'd1;
         2'b01:   count_next = count - 11'd1;
         default: count_next = count;
      endcase
   end

   // Pointers, fill level and flags; flags are registered from the next level
   always_ff @(posedge wr_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         wr_full      <= 1'b0;
         almost_full  <= 1'b0;
         rd_empty     <= 1'b1;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 10'd1;
         if (rd_acc) rd_ptr <= rd_ptr + 10'd1;
         count        <= count_next;
         wr_full      <= (count_next == DEPTH);
         almost_full  <= (count_next >= AF_LEVEL);
         rd_empty     <= (count_next == 11'd0);
         almost_empty <= (count_next <= AE_LEVEL);
      end
   end

   // Storage write port
   always_ff @(posedge wr_clk) begin
      // NOTE: the RAM has no reset so it maps onto a block RAM; stale words are unreachable after reset.
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   // Registered read data; holds its value when no read is accepted
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_acc) begin
         rd_data <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fifo_1024x32b.sv
// tb_fifo_1024x32b: directed bench for fifo_1024x32b with a queue-based
// reference model compared on every falling edge, plus literal expectations.
module tb_fifo_1024x32b;

   logic        clk = 1'b0;
   logic        wr_rst;
   logic        rd_rst;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        rd_en;
   logic        wr_full;
   logic        almost_full;
   logic [31:0] rd_data;
   logic        rd_empty;
   logic [10:0] rd_water_level;
   logic        almost_empty;
`ifdef FIFO_WR_WATER_LEVEL_EN
   logic [10:0] wr_water_level;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          cmp_en   = 1'b0;
   logic [31:0] q [$];
   logic [31:0] m_data;

   always #5 clk = ~clk;

   fifo_1024x32b dut (
      .wr_clk         (clk),
      .rd_clk         (clk),
      .wr_rst         (wr_rst),
      .rd_rst         (rd_rst),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_full        (wr_full),
      .almost_full    (almost_full),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_empty       (rd_empty),
      .rd_water_level (rd_water_level),
`ifdef FIFO_WR_WATER_LEVEL_EN
      .wr_water_level (wr_water_level),
`endif
      .almost_empty   (almost_empty)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: an unbounded queue limited to 1024 entries
   always @(posedge clk) begin : model
      int sz;
      sz = q.size();
      if (wr_rst || rd_rst) begin
         q.delete();
         m_data <= '0;
      end else begin
         if (rd_en && sz > 0) m_data <= q.pop_front();
         if (wr_en && sz < 1024) q.push_back(wr_data);
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin : compare
      int lvl;
      if (cmp_en) begin
         lvl = q.size();
         check("level",        32'(rd_water_level), 32'(lvl));
         check("rd_empty",     32'(rd_empty),       32'(lvl == 0));
         check("wr_full",      32'(wr_full),        32'(lvl == 1024));
         check("almost_full",  32'(almost_full),    32'(lvl >= 1020));
         check("almost_empty", 32'(almost_empty),   32'(lvl <= 4));
         check("rd_data",      rd_data,             m_data);
`ifdef FIFO_WR_WATER_LEVEL_EN
         check("wr_level",     32'(wr_water_level), 32'(lvl));
`endif
      end
   end

   // One clock cycle: drive inputs at the falling edge, return at the next falling edge
   task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      wr_rst  = 1'b1;
      rd_rst  = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;

      // Reset held for 20 cycles
      cyc(1'b0, 32'h0, 1'b0);
      cmp_en = 1'b1;
      repeat (19) cyc(1'b0, 32'h0, 1'b0);
      wr_rst = 1'b0;
      check("rst_rd_empty",     32'(rd_empty),       32'd1);
      check("rst_almost_empty", 32'(almost_empty),   32'd1);
      check("rst_wr_full",      32'(wr_full),        32'd0);
      check("rst_almost_full",  32'(almost_full),    32'd0);
      check("rst_level",        32'(rd_water_level), 32'd0);
      check("rst_rd_data",      rd_data,             32'h0);

      // Fill with 1025 descending words; the last one is dropped
      for (int i = 0; i < 1025; i++) begin
         cyc(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0);
         if (i == 3)    check("fill_ae_lvl4",   32'(almost_empty),   32'd1);
         if (i == 4)    check("fill_ae_lvl5",   32'(almost_empty),   32'd0);
         if (i == 1018) check("fill_af_lvl1019", 32'(almost_full),   32'd0);
         if (i == 1019) check("fill_af_lvl1020", 32'(almost_full),   32'd1);
         if (i == 1022) check("fill_full_1023", 32'(wr_full),        32'd0);
         if (i == 1023) check("fill_full_1024", 32'(wr_full),        32'd1);
         if (i == 1024) check("fill_drop_lvl",  32'(rd_water_level), 32'd1024);
      end

      // Drain with 1025 reads; the last one is rejected
      for (int i = 0; i < 1025; i++) begin
         cyc(1'b0, 32'h0, 1'b1);
         if (i == 0)    check("drain_first",    rd_data,             32'hFFFF_FFFF);
         if (i == 1022) check("drain_empty_1", 32'(rd_empty),        32'd0);
         if (i == 1023) check("drain_empty_0", 32'(rd_empty),        32'd1);
         if (i == 1023) check("drain_last",    rd_data,              32'hFFFF_FC00);
         if (i == 1024) check("drain_hold",    rd_data,              32'hFFFF_FC00);
         if (i == 1024) check("drain_level",   32'(rd_water_level),  32'd0);
      end

      // Level 10, then 50 cycles of simultaneous read and write
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'd100 + 32'(i), 1'b0);
      for (int k = 0; k < 50; k++) begin
         cyc(1'b1, 32'd200 + 32'(k), 1'b1);
         if (k == 0) check("simul_first", rd_data, 32'd100);
      end
      check("simul_level", 32'(rd_water_level), 32'd10);
      check("simul_last",  rd_data,             32'd239);

      // Fill to full, then read and write together at full
      for (int i = 0; i < 1014; i++) cyc(1'b1, 32'd1000 + 32'(i), 1'b0);
      check("race_full_pre", 32'(wr_full), 32'd1);
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1);
      check("race_full_level", 32'(rd_water_level), 32'd1023);
      check("race_full_flag",  32'(wr_full),        32'd0);
      check("race_full_data",  rd_data,             32'd240);

      // Drain the rest; the discarded write must not appear
      for (int i = 0; i < 1023; i++) cyc(1'b0, 32'h0, 1'b1);
      check("race_drain_last",  rd_data,        32'd2013);
      check("race_drain_empty", 32'(rd_empty),  32'd1);

      // Read and write together at empty
      cyc(1'b1, 32'd5555, 1'b1);
      check("race_empty_level", 32'(rd_water_level), 32'd1);
      check("race_empty_data",  rd_data,             32'd2013);
      cyc(1'b0, 32'h0, 1'b1);
      check("race_empty_read",  rd_data,             32'd5555);

      // Reset via rd_rst at level 500
      for (int i = 0; i < 500; i++) cyc(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
      check("mid_pre_level", 32'(rd_water_level), 32'd500);
      rd_rst = 1'b1;
      cyc(1'b0, 32'h0, 1'b0);
      rd_rst = 1'b0;
      check("mid_rst_level", 32'(rd_water_level), 32'd0);
      check("mid_rst_empty", 32'(rd_empty),       32'd1);
      check("mid_rst_data",  rd_data,             32'h0);
      cyc(1'b1, 32'hABCD_1234, 1'b0);
      cyc(1'b0, 32'h0, 1'b1);
      check("mid_new_data",  rd_data,             32'hABCD_1234);
      check("mid_new_empty", 32'(rd_empty),       32'd1);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
